// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - carry-segmented pipelined add/sub with valid/ready and sticky overflow
// Optional feature: define ADDSUB_PIPE_SAT_EN to clamp sum on signed overflow.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [SEG:0]     seg_sum;
  logic             msb_cin;

  // Inputs seen by each stage: stage 0 takes the ports, stage k the registers of stage k-1.
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic             src_v [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_d [STAGES];
  logic             c_q [STAGES];
  logic             v_d [STAGES];
  logic             v_q [STAGES];
  logic             ovf_d;
  logic             ovf_q;
  logic             sticky_d;
  logic             sticky_q;

  always_comb begin
    adv      = !v_q[STAGES-1] || out_ready;
    src_a[0] = x;
    src_b[0] = y ^ {WIDTH{sel}};
    src_s[0] = '0;
    src_c[0] = sel;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end

    // Upper operand bits ride along untouched (skew); resolved sum bits accumulate (de-skew).
    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, src_c[k]};
      a_d[k]               = src_a[k];
      b_d[k]               = src_b[k];
      s_d[k]               = src_s[k];
      s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]               = seg_sum[SEG];
      v_d[k]               = src_v[k];
    end

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    msb_cin = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1] ^ s_d[STAGES-1][WIDTH-1];
    ovf_d   = msb_cin ^ c_d[STAGES-1];
`ifdef ADDSUB_PIPE_SAT_EN
    if (ovf_d) begin
      s_d[STAGES-1] = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    if (!adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_d[k] = a_q[k];
        b_d[k] = b_q[k];
        s_d[k] = s_q[k];
        c_d[k] = c_q[k];
        v_d[k] = v_q[k];
      end
      ovf_d = ovf_q;
    end

    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (v_q[STAGES-1] && out_ready && ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = v_q[STAGES-1];
  assign sum        = s_q[STAGES-1];
  assign c_out      = c_q[STAGES-1];
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the team's ripple add/sub datapath, generalised to any width and split into carry-segmented pipeline stages. Accepts one operation per cycle over a valid/ready handshake and returns the sum, carry-out and signed overflow `STAGES` cycles later, with full backpressure and a sticky overflow flag. It sits between operand-producing logic and result consumers in the arithmetic datapath.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width in bits; must be a multiple of `SEG`.
- `SEG`, 4: bits resolved per pipeline stage; `STAGES = WIDTH/SEG` (local, derived).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `x`, `y`  in  WIDTH each  operands.
- `sel`  in  1  0 = add (x+y), 1 = subtract (x−y).
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  WIDTH  result.
- `c_out`  out  1  carry out of MSB.
- `overflow`  out  1  signed overflow of this result.
- `ovf_sticky`  out  1  set by any overflow that handshakes out; held until cleared.
- `clr_sticky`  in  1  synchronous clear of `ovf_sticky`.

## Operation
- Subtract: y inverted bitwise (y XOR sel), carry-in to segment 0 = `sel`.
- Stage k (k=0..STAGES−1) adds segment k of x and conditioned y plus carry registered from stage k−1; produces SEG sum bits and carry.
- Upper operand segments are skewed (delayed) so each reaches its stage with the matching carry; completed lower sum segments are de-skewed so all of `sum` emerges together.
- `c_out` = carry out of bit WIDTH−1; `overflow` = carry into bit WIDTH−1 XOR `c_out`. Both computed in the final stage.
- Pipeline is a single global-enable shift: `adv = !out_valid || out_ready`; `in_ready = adv`. When `adv`=0 every stage holds, including bubbles.
- Per-stage valid bit shifts with data; bubbles (in_valid=0 while adv) travel as valid=0.
- `ovf_sticky` sets on the cycle `out_valid && out_ready && overflow`; `clr_sticky` clears it; simultaneous set and clear → set wins (remains 1).
- Reset (async assert): all valid bits, `out_valid`, `sum`, `c_out`, `overflow`, `ovf_sticky` → 0; in-flight operations discarded. `in_ready` reads 1 during and after reset. Deassertion is synchronised by the integrator; first accept on first edge after release.

## Timing
- Latency: beat accepted at edge N appears on `out_valid` after edge N+STAGES−1 (i.e. STAGES register stages; 4 for defaults), assuming no stall.
- Throughput: one op per cycle while `out_ready`=1.
- Stall: each cycle with `out_valid`=1, `out_ready`=0 freezes all stages and drops `in_ready`; outputs stable until accepted.
- `in_ready` is combinational from `out_ready` and `out_valid` only; no path from `in_valid` to `in_ready`.
- All outputs registered except `in_ready`.

## Configuration
- `ADDSUB_PIPE_SAT_EN` defined: on overflow, `sum` clamps to 0x7F..F when the true result is positive (final-stage operand MSBs both 0 after conditioning) or 0x80..0 when negative; `overflow`, `c_out`, sticky still report the event.
- Undefined: `sum` is the wrapped modulo-2^WIDTH result; saturation logic absent.

## Test plan
(WIDTH=16, SEG=4, latency 4)
- add 0x7FFF + 0x0001 → `sum` 0x8000, `overflow` 1, `c_out` 0, `ovf_sticky` 1 after handshake (with SAT_EN: `sum` 0x7FFF).
- sub 0x0005 − 0x0007 → `sum` 0xFFFE, `c_out` 0, `overflow` 0; sub 0x8000 − 0x0001 → `sum` 0x7FFF, `c_out` 1, `overflow` 1 (SAT_EN: 0x8000).
- 8 back-to-back random ops, `out_ready` low for 3 cycles mid-stream → `in_ready` low exactly those cycles, all 8 results in order, none lost/duplicated, outputs stable during stall.
- alternating `in_valid` 1/0 → results emerge with matching single-cycle bubbles, 4 cycles after each accept.
- `rst_n` pulsed low with 3 ops in flight → `out_valid` and all flags 0 immediately; no stale result after release; next op correct.
- overflow result handshakes out in same cycle as `clr_sticky`=1 → `ovf_sticky` stays 1; `clr_sticky` alone next cycle → 0.
